// File: rtl/hssl_cfg_apb_master.sv
// ---------------------------------------------------------------------------
// hssl_cfg_apb_master
//
// APB initiator fed by configuration packets from the HSSL link. Each
// accepted config packet (key + optional payload) becomes exactly one APB
// read or write on the register bank. A read returns its data to the host
// as a reply packet keyed with reply_key_in OR'd with the register address.
//
// Key layout: [REG_ADR_BITS-1:0] register word address,
//             [REG_ADR_BITS]     1 = write, 0 = read,
//             masked upper bits  must equal CFG_KEY under CFG_MSK.
//
// Optional feature (macro HSSL_CFG_TIMEOUT_EN): abort an ACCESS phase that
// sees no pready for TIMEOUT cycles. An aborted read replies with
// 0xdead_beef, an aborted write returns to IDLE, and drop_out pulses.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   pkt_key_in/data_in/pld_in   incoming packet key, payload, payload-present
//   pkt_vld_in, pkt_rdy_out     incoming packet handshake (ready only in IDLE)
//   reply_key_in                base key for reply packets
//   rpy_key_out/data_out        reply packet key and payload
//   rpy_vld_out, rpy_rdy_in     reply packet handshake
//   apb_*                       APB initiator interface
//   drop_out                    one-cycle pulse on a discarded packet/abort
// ---------------------------------------------------------------------------
module hssl_cfg_apb_master #(
  parameter int unsigned APB_ADR_BITS = 16,
  parameter int unsigned REG_ADR_BITS = 8,
  parameter logic [31:0] CFG_KEY      = 32'hffff_fe00,
  parameter logic [31:0] CFG_MSK      = 32'hffff_fe00
`ifdef HSSL_CFG_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT      = 255
`endif
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [31:0]             pkt_key_in,
  input  logic [31:0]             pkt_data_in,
  input  logic                    pkt_pld_in,
  input  logic                    pkt_vld_in,
  output logic                    pkt_rdy_out,
  input  logic [31:0]             reply_key_in,
  output logic [31:0]             rpy_key_out,
  output logic [31:0]             rpy_data_out,
  output logic                    rpy_vld_out,
  input  logic                    rpy_rdy_in,
  output logic                    apb_psel_out,
  output logic                    apb_penable_out,
  output logic                    apb_pwrite_out,
  output logic [APB_ADR_BITS-1:0] apb_paddr_out,
  output logic [31:0]             apb_pwdata_out,
  input  logic [31:0]             apb_prdata_in,
  input  logic                    apb_pready_in,
  input  logic                    apb_pslverr_in,
  output logic                    drop_out
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_REPLY  = 2'd3
  } state_t;

  localparam logic [31:0] ERR_DATA = 32'hffff_ffff;

`ifdef HSSL_CFG_TIMEOUT_EN
  localparam logic [31:0] TMO_DATA = 32'hdead_beef;
  // Last ACCESS cycle index that may still see pready before the abort.
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);
`endif

  state_t                  state_r;
  state_t                  state_s;

  logic                    match_s;
  logic                    wr_s;
  logic [REG_ADR_BITS-1:0] addr_s;
  logic                    xfer_s;
  logic                    start_s;
  logic                    drop_s;
  logic                    ld_rpy_s;
  logic [31:0]             rpy_data_s;

  logic [REG_ADR_BITS-1:0] addr_r;
  logic                    pwrite_r;
  logic [31:0]             pwdata_r;
  logic [31:0]             rpy_key_r;
  logic [31:0]             rpy_data_r;
  logic                    psel_r;
  logic                    penable_r;
  logic                    rpy_vld_r;
  logic                    drop_r;

`ifdef HSSL_CFG_TIMEOUT_EN
  logic [7:0]              tmo_cnt_r;
  logic                    tmo_inc_s;
`endif

  // Key decode of the packet currently offered.
  assign match_s = ((pkt_key_in & CFG_MSK) == (CFG_KEY & CFG_MSK));
  assign wr_s    = pkt_key_in[REG_ADR_BITS];
  assign addr_s  = pkt_key_in[REG_ADR_BITS-1:0];

  // Ready is a pure state decode; held low while reset is asserted so that
  // every output reads 0 during reset.
  assign pkt_rdy_out = resetn && (state_r == ST_IDLE);
  assign xfer_s      = pkt_vld_in && pkt_rdy_out;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and datapath load-enable decode.
  always_comb begin
    state_s    = state_r;
    start_s    = 1'b0;
    drop_s     = 1'b0;
    ld_rpy_s   = 1'b0;
    rpy_data_s = apb_prdata_in;
`ifdef HSSL_CFG_TIMEOUT_EN
    tmo_inc_s  = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) begin
          // Reads ignore the payload; a write must carry one to be valid.
          if (match_s && (!wr_s || pkt_pld_in)) begin
            start_s = 1'b1;
            state_s = ST_SETUP;
          end else begin
            drop_s  = 1'b1;
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_s = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apb_pready_in) begin
          if (pwrite_r) begin
            state_s = ST_IDLE;
          end else begin
            state_s    = ST_REPLY;
            ld_rpy_s   = 1'b1;
            rpy_data_s = apb_pslverr_in ? ERR_DATA : apb_prdata_in;
          end
        end else begin
`ifdef HSSL_CFG_TIMEOUT_EN
          if (tmo_cnt_r == TMO_LAST) begin
            drop_s = 1'b1;
            if (pwrite_r) begin
              state_s = ST_IDLE;
            end else begin
              state_s    = ST_REPLY;
              ld_rpy_s   = 1'b1;
              rpy_data_s = TMO_DATA;
            end
          end else begin
            tmo_inc_s = 1'b1;
            state_s   = ST_ACCESS;
          end
`else
          state_s = ST_ACCESS;
`endif
        end
      end
      ST_REPLY: begin
        if (rpy_rdy_in) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_REPLY;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Control outputs registered from the next state so they align with it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
      rpy_vld_r <= 1'b0;
      drop_r    <= 1'b0;
    end else begin
      psel_r    <= (state_s == ST_SETUP) || (state_s == ST_ACCESS);
      penable_r <= (state_s == ST_ACCESS);
      rpy_vld_r <= (state_s == ST_REPLY);
      drop_r    <= drop_s;
    end
  end

  // Transaction address/data capture; held stable for the whole transfer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_r   <= {REG_ADR_BITS{1'b0}};
      pwrite_r <= 1'b0;
      pwdata_r <= 32'h0000_0000;
    end else begin
      if (start_s) begin
        addr_r   <= addr_s;
        pwrite_r <= wr_s;
        if (wr_s) begin
          pwdata_r <= pkt_data_in;
        end else begin
          pwdata_r <= pwdata_r;
        end
      end else begin
        addr_r   <= addr_r;
        pwrite_r <= pwrite_r;
        pwdata_r <= pwdata_r;
      end
    end
  end

  // Reply key/data captured once on REPLY entry so they stay stable while
  // the host stalls, even if reply_key_in changes meanwhile.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rpy_key_r  <= 32'h0000_0000;
      rpy_data_r <= 32'h0000_0000;
    end else begin
      if (ld_rpy_s) begin
        rpy_key_r  <= reply_key_in | 32'(addr_r);
        rpy_data_r <= rpy_data_s;
      end else begin
        rpy_key_r  <= rpy_key_r;
        rpy_data_r <= rpy_data_r;
      end
    end
  end

`ifdef HSSL_CFG_TIMEOUT_EN
  // ACCESS cycle counter: cleared as SETUP is entered, counts stalled cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt_r <= 8'd0;
    end else begin
      if (start_s) begin
        tmo_cnt_r <= 8'd0;
      end else if (tmo_inc_s) begin
        tmo_cnt_r <= tmo_cnt_r + 8'd1;
      end else begin
        tmo_cnt_r <= tmo_cnt_r;
      end
    end
  end
`endif

  assign apb_psel_out    = psel_r;
  assign apb_penable_out = penable_r;
  assign apb_pwrite_out  = pwrite_r;
  assign apb_paddr_out   = APB_ADR_BITS'({addr_r, 2'b00});
  assign apb_pwdata_out  = pwdata_r;
  assign rpy_vld_out     = rpy_vld_r;
  assign rpy_key_out     = rpy_key_r;
  assign rpy_data_out    = rpy_data_r;
  assign drop_out        = drop_r;

endmodule

// File: tb/tb_hssl_cfg_apb_master.sv
// ---------------------------------------------------------------------------
// tb_hssl_cfg_apb_master
//
// Directed bench for hssl_cfg_apb_master. Inputs change 1 time unit after
// the rising edge and outputs are compared at that same point, so each
// "cycle N" below is the state after the Nth rising edge following the
// cycle in which the packet was offered (cycle 0).
// ---------------------------------------------------------------------------
module tb_hssl_cfg_apb_master;

  logic        clk;
  logic        resetn;
  logic [31:0] pkt_key_in;
  logic [31:0] pkt_data_in;
  logic        pkt_pld_in;
  logic        pkt_vld_in;
  logic        pkt_rdy_out;
  logic [31:0] reply_key_in;
  logic [31:0] rpy_key_out;
  logic [31:0] rpy_data_out;
  logic        rpy_vld_out;
  logic        rpy_rdy_in;
  logic        apb_psel_out;
  logic        apb_penable_out;
  logic        apb_pwrite_out;
  logic [15:0] apb_paddr_out;
  logic [31:0] apb_pwdata_out;
  logic [31:0] apb_prdata_in;
  logic        apb_pready_in;
  logic        apb_pslverr_in;
  logic        drop_out;

  int checks_cnt;
  int errors_cnt;

`ifdef HSSL_CFG_TIMEOUT_EN
  hssl_cfg_apb_master #(.TIMEOUT(4)) dut (
`else
  hssl_cfg_apb_master dut (
`endif
    .clk             (clk),
    .resetn          (resetn),
    .pkt_key_in      (pkt_key_in),
    .pkt_data_in     (pkt_data_in),
    .pkt_pld_in      (pkt_pld_in),
    .pkt_vld_in      (pkt_vld_in),
    .pkt_rdy_out     (pkt_rdy_out),
    .reply_key_in    (reply_key_in),
    .rpy_key_out     (rpy_key_out),
    .rpy_data_out    (rpy_data_out),
    .rpy_vld_out     (rpy_vld_out),
    .rpy_rdy_in      (rpy_rdy_in),
    .apb_psel_out    (apb_psel_out),
    .apb_penable_out (apb_penable_out),
    .apb_pwrite_out  (apb_pwrite_out),
    .apb_paddr_out   (apb_paddr_out),
    .apb_pwdata_out  (apb_pwdata_out),
    .apb_prdata_in   (apb_prdata_in),
    .apb_pready_in   (apb_pready_in),
    .apb_pslverr_in  (apb_pslverr_in),
    .drop_out        (drop_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] key, input logic [31:0] data, input logic pld);
    pkt_key_in  = key;
    pkt_data_in = data;
    pkt_pld_in  = pld;
    pkt_vld_in  = 1'b1;
  endtask

  initial begin
    checks_cnt    = 0;
    errors_cnt    = 0;
    resetn        = 1'b0;
    pkt_key_in    = 32'h0;
    pkt_data_in   = 32'h0;
    pkt_pld_in    = 1'b0;
    pkt_vld_in    = 1'b0;
    reply_key_in  = 32'hffff_fd00;
    rpy_rdy_in    = 1'b1;
    apb_prdata_in = 32'h0;
    apb_pready_in = 1'b1;
    apb_pslverr_in = 1'b0;

    // Reset values.
    #12;
    check_val("rst_rdy",    {31'd0, pkt_rdy_out},     32'd0);
    check_val("rst_psel",   {31'd0, apb_psel_out},    32'd0);
    check_val("rst_pen",    {31'd0, apb_penable_out}, 32'd0);
    check_val("rst_rvld",   {31'd0, rpy_vld_out},     32'd0);
    check_val("rst_paddr",  {16'd0, apb_paddr_out},   32'd0);
    check_val("rst_rkey",   rpy_key_out,              32'd0);
    check_val("rst_drop",   {31'd0, drop_out},        32'd0);
    resetn = 1'b1;
    tick();

    // Write 0x40 to register 0x12 with zero wait states.
    offer(32'hffff_ff12, 32'h0000_0040, 1'b1);
    check_val("wr_rdy0", {31'd0, pkt_rdy_out}, 32'd1);
    tick();
    pkt_vld_in = 1'b0;
    check_val("wr_psel1",  {31'd0, apb_psel_out},    32'd1);
    check_val("wr_pen1",   {31'd0, apb_penable_out}, 32'd0);
    check_val("wr_paddr",  {16'd0, apb_paddr_out},   32'h0000_0048);
    check_val("wr_pwdata", apb_pwdata_out,           32'h0000_0040);
    check_val("wr_pwrite", {31'd0, apb_pwrite_out},  32'd1);
    check_val("wr_rdy1",   {31'd0, pkt_rdy_out},     32'd0);
    tick();
    check_val("wr_psel2",  {31'd0, apb_psel_out},    32'd1);
    check_val("wr_pen2",   {31'd0, apb_penable_out}, 32'd1);
    tick();
    check_val("wr_psel3",  {31'd0, apb_psel_out},    32'd0);
    check_val("wr_pen3",   {31'd0, apb_penable_out}, 32'd0);
    check_val("wr_rdy3",   {31'd0, pkt_rdy_out},     32'd1);
    check_val("wr_norpy",  {31'd0, rpy_vld_out},     32'd0);

    // Read of register 0x0f, pready held off for 3 ACCESS cycles.
    apb_pready_in = 1'b0;
    apb_prdata_in = 32'h5ec0_0001;
    offer(32'hffff_fe0f, 32'h0000_0000, 1'b0);
    tick();
    pkt_vld_in = 1'b0;
    check_val("rd_paddr",  {16'd0, apb_paddr_out},   32'h0000_003c);
    check_val("rd_pwrite", {31'd0, apb_pwrite_out},  32'd0);
    check_val("rd_pen1",   {31'd0, apb_penable_out}, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check_val("rd_pen_wait", {31'd0, apb_penable_out}, 32'd1);
      tick();
    end
    apb_pready_in = 1'b1;
    check_val("rd_pen_last", {31'd0, apb_penable_out}, 32'd1);
    tick();
    check_val("rd_rvld",  {31'd0, rpy_vld_out},     32'd1);
    check_val("rd_rkey",  rpy_key_out,              32'hffff_fd0f);
    check_val("rd_rdata", rpy_data_out,             32'h5ec0_0001);
    check_val("rd_psel0", {31'd0, apb_psel_out},    32'd0);
    tick();
    check_val("rd_rvld0", {31'd0, rpy_vld_out},     32'd0);
    check_val("rd_rdy",   {31'd0, pkt_rdy_out},     32'd1);

    // Read with reply back-pressure; a second packet waits behind it.
    apb_prdata_in = 32'h1111_2222;
    rpy_rdy_in    = 1'b0;
    offer(32'hffff_fe33, 32'h0000_0000, 1'b0);
    tick();
    offer(32'hffff_ff05, 32'h0000_abcd, 1'b1);
    check_val("bp_rdy1", {31'd0, pkt_rdy_out}, 32'd0);
    tick();
    check_val("bp_rdy2", {31'd0, pkt_rdy_out}, 32'd0);
    tick();
    reply_key_in = 32'h0000_0000;
    for (int i = 0; i < 5; i++) begin
      check_val("bp_rvld",  {31'd0, rpy_vld_out}, 32'd1);
      check_val("bp_rkey",  rpy_key_out,          32'hffff_fd33);
      check_val("bp_rdata", rpy_data_out,         32'h1111_2222);
      check_val("bp_rdy",   {31'd0, pkt_rdy_out}, 32'd0);
      tick();
    end
    rpy_rdy_in = 1'b1;
    check_val("bp_rvld6", {31'd0, rpy_vld_out}, 32'd1);
    check_val("bp_rkey6", rpy_key_out,          32'hffff_fd33);
    tick();
    check_val("bp_rvld_off", {31'd0, rpy_vld_out}, 32'd0);
    check_val("bp_rdy_on",   {31'd0, pkt_rdy_out}, 32'd1);
    tick();
    pkt_vld_in = 1'b0;
    reply_key_in = 32'hffff_fd00;
    check_val("bp2_psel",   {31'd0, apb_psel_out},   32'd1);
    check_val("bp2_paddr",  {16'd0, apb_paddr_out},  32'h0000_0014);
    check_val("bp2_pwdata", apb_pwdata_out,          32'h0000_abcd);
    check_val("bp2_pwrite", {31'd0, apb_pwrite_out}, 32'd1);
    tick();
    tick();
    check_val("bp2_idle", {31'd0, pkt_rdy_out}, 32'd1);

    // Non-matching key, then a write key without payload.
    offer(32'h1234_5678, 32'h0000_0001, 1'b1);
    tick();
    check_val("dr1_drop", {31'd0, drop_out},     32'd1);
    check_val("dr1_psel", {31'd0, apb_psel_out}, 32'd0);
    check_val("dr1_rdy",  {31'd0, pkt_rdy_out},  32'd1);
    offer(32'hffff_ff20, 32'h0000_0002, 1'b0);
    tick();
    pkt_vld_in = 1'b0;
    check_val("dr2_drop", {31'd0, drop_out},     32'd1);
    check_val("dr2_psel", {31'd0, apb_psel_out}, 32'd0);
    check_val("dr2_paddr", {16'd0, apb_paddr_out}, 32'h0000_0014);
    tick();
    check_val("dr3_drop", {31'd0, drop_out},     32'd0);
    check_val("dr3_psel", {31'd0, apb_psel_out}, 32'd0);

    // Reset asserted during a stalled ACCESS.
    apb_pready_in = 1'b0;
    offer(32'hffff_fe01, 32'h0000_0000, 1'b0);
    tick();
    pkt_vld_in = 1'b0;
    tick();
    check_val("ra_pen", {31'd0, apb_penable_out}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_val("ra_psel", {31'd0, apb_psel_out},    32'd0);
    check_val("ra_pen0", {31'd0, apb_penable_out}, 32'd0);
    check_val("ra_rvld", {31'd0, rpy_vld_out},     32'd0);
    check_val("ra_paddr", {16'd0, apb_paddr_out},  32'd0);
    #3;
    resetn = 1'b1;
    tick();
    check_val("ra_rdy", {31'd0, pkt_rdy_out}, 32'd1);
    check_val("ra_norpy", {31'd0, rpy_vld_out}, 32'd0);

    // Read after reset, slave error forces all-ones data.
    apb_pready_in  = 1'b1;
    apb_pslverr_in = 1'b1;
    apb_prdata_in  = 32'h0000_00aa;
    offer(32'hffff_fe02, 32'h0000_0000, 1'b0);
    tick();
    pkt_vld_in = 1'b0;
    check_val("pr_paddr", {16'd0, apb_paddr_out}, 32'h0000_0008);
    tick();
    tick();
    apb_pslverr_in = 1'b0;
    check_val("pr_rvld",  {31'd0, rpy_vld_out}, 32'd1);
    check_val("pr_rkey",  rpy_key_out,          32'hffff_fd02);
    check_val("pr_rdata", rpy_data_out,         32'hffff_ffff);
    tick();
    check_val("pr_rvld0", {31'd0, rpy_vld_out}, 32'd0);

`ifdef HSSL_CFG_TIMEOUT_EN
    // Stalled read aborts after 4 ACCESS cycles.
    apb_pready_in = 1'b0;
    offer(32'hffff_fe07, 32'h0000_0000, 1'b0);
    tick();
    pkt_vld_in = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check_val("to_pen", {31'd0, apb_penable_out}, 32'd1);
      check_val("to_nodrop", {31'd0, drop_out}, 32'd0);
      tick();
    end
    check_val("to_psel0", {31'd0, apb_psel_out}, 32'd0);
    check_val("to_pen0",  {31'd0, apb_penable_out}, 32'd0);
    check_val("to_drop",  {31'd0, drop_out}, 32'd1);
    check_val("to_rvld",  {31'd0, rpy_vld_out}, 32'd1);
    check_val("to_rkey",  rpy_key_out, 32'hffff_fd07);
    check_val("to_rdata", rpy_data_out, 32'hdead_beef);
    tick();
    check_val("to_drop0", {31'd0, drop_out}, 32'd0);
    check_val("to_rvld0", {31'd0, rpy_vld_out}, 32'd0);
    apb_pready_in = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
